// File: rtl/mcs4_ram_host_bridge_pkg.sv
// rtl/mcs4_ram_host_bridge_pkg.sv - MCS-4 RAM bus types shared by the host bridge
package mcs4_ram_host_bridge_pkg;

    // One 4-bit MCS-4 data nibble
    typedef logic [3:0] char_t;

    // Instruction phases, one per clk, A1 first and X3 last
    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    // I/O and RAM instruction group (OPR 0xE); bit 3 set means the RAM drives data back
    typedef enum logic [3:0] {
        OPA_WRM = 4'h0,
        OPA_WMP = 4'h1,
        OPA_WRR = 4'h2,
        OPA_WPM = 4'h3,
        OPA_WR0 = 4'h4,
        OPA_WR1 = 4'h5,
        OPA_WR2 = 4'h6,
        OPA_WR3 = 4'h7,
        OPA_SBM = 4'h8,
        OPA_RDM = 4'h9,
        OPA_RDR = 4'hA,
        OPA_ADM = 4'hB,
        OPA_RD0 = 4'hC,
        OPA_RD1 = 4'hD,
        OPA_RD2 = 4'hE,
        OPA_RD3 = 4'hF
    } ioram_opa_t;

    // Bridge frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SRC  = 2'd1,
        ST_CMD  = 2'd2
    } bridge_state_t;

    // Read-class opcodes expect the RAM to drive dbus during X2
    function automatic logic ioram_is_read(input ioram_opa_t opa);
        return opa[3];
    endfunction

endpackage

// File: rtl/mcs4_ram_host_bridge.sv
// rtl/mcs4_ram_host_bridge.sv - valid/ready host master generating SRC and I/O-RAM frames for i4002 RAMs
module mcs4_ram_host_bridge
    import mcs4_ram_host_bridge_pkg::*;
#(
    parameter bit SKIP_SRC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_opa,
    input  logic [1:0] req_chip,
    input  logic [1:0] req_reg,
    input  logic [3:0] req_char,
    input  logic [3:0] req_wdata,
    output logic       rsp_valid,
    output logic [3:0] rsp_rdata,
    output logic       sync,
    output logic       cm_ram,
    output logic [3:0] dbus_out,
    input  logic [3:0] dbus_in
);

    instr_cyc_t    phase;
    instr_cyc_t    phase_nxt;
    bridge_state_t state;

    // Request fields captured at accept, held for the SRC and CMD frames
    ioram_opa_t    opa_q;
    logic [1:0]    chip_q;
    logic [1:0]    reg_q;
    char_t         char_q;
    char_t         wdata_q;

    // Address last sent in an SRC frame; the RAMs still hold it
    logic          cache_valid;
    logic [1:0]    cache_chip;
    logic [1:0]    cache_reg;
    char_t         cache_char;

    logic          accept;
    logic          cache_hit;
    logic          cm_nxt;
    char_t         dbus_nxt;

    assign phase_nxt = instr_cyc_t'(phase + 3'd1);

    // The RAMs restart their phase count on sync, so reset doubles as a sync pulse
    assign sync      = rst || (phase == X3);
    assign req_ready = !rst && (phase == X3) && ((state == ST_IDLE) || (state == ST_CMD));
    assign accept    = req_valid && req_ready;
    assign cache_hit = SKIP_SRC && cache_valid &&
                       ({req_chip, req_reg, req_char} == {cache_chip, cache_reg, cache_char});

    // Free-running phase counter; parked on X3 in reset so A1 follows release
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= X3;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Frame sequencer: state, request latch and SRC cache change only on the X3->A1 edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            opa_q       <= OPA_WRM;
            chip_q      <= '0;
            reg_q       <= '0;
            char_q      <= '0;
            wdata_q     <= '0;
            cache_valid <= 1'b0;
            cache_chip  <= '0;
            cache_reg   <= '0;
            cache_char  <= '0;
        end else if (phase == X3) begin
            if (state == ST_SRC) begin
                cache_valid <= 1'b1;
                cache_chip  <= chip_q;
                cache_reg   <= reg_q;
                cache_char  <= char_q;
                state       <= ST_CMD;
            end else if (accept) begin
                opa_q   <= ioram_opa_t'(req_opa);
                chip_q  <= req_chip;
                reg_q   <= req_reg;
                char_q  <= req_char;
                wdata_q <= req_wdata;
                state   <= cache_hit ? ST_CMD : ST_SRC;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Bus drive for the phase that starts at the next edge; A1 is always quiet
    always_comb begin
        cm_nxt   = 1'b0;
        dbus_nxt = '0;
        if (state == ST_SRC) begin
            if (phase_nxt == X2) begin
                cm_nxt   = 1'b1;
                dbus_nxt = {chip_q, reg_q};
            end else if (phase_nxt == X3) begin
                dbus_nxt = char_q;
            end
        end else if (state == ST_CMD) begin
            if (phase_nxt == M2) begin
                cm_nxt   = 1'b1;
                dbus_nxt = opa_q;
            end else if ((phase_nxt == X2) && !ioram_is_read(opa_q)) begin
                dbus_nxt = wdata_q;
            end
        end
    end

    // Registered bus and response outputs; read data is taken on the edge ending X2
    always_ff @(posedge clk) begin
        if (rst) begin
            cm_ram    <= 1'b0;
            dbus_out  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            cm_ram    <= cm_nxt;
            dbus_out  <= dbus_nxt;
            rsp_valid <= (state == ST_CMD) && (phase_nxt == X3);
            if ((state == ST_CMD) && (phase == X2)) begin
                rsp_rdata <= ioram_is_read(opa_q) ? dbus_in : 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_mcs4_ram_host_bridge.sv
// tb/tb_mcs4_ram_host_bridge.sv - scoreboard bench: two bridges (SRC skip on/off) driving a two-chip RAM model
module tb_mcs4_ram_host_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ram_clr = 1'b1;

    logic       req_valid_a = 1'b0;
    logic       req_valid_b = 1'b0;
    logic [3:0] req_opa = '0;
    logic [1:0] req_chip = '0;
    logic [1:0] req_reg = '0;
    logic [3:0] req_char = '0;
    logic [3:0] req_wdata = '0;

    logic       ready_a, ready_b, rsp_valid_a, rsp_valid_b;
    logic [3:0] rdata_a, rdata_b;
    logic       sync_a, sync_b, cm_a, cm_b;
    logic [3:0] dbus_a, dbus_b;
    logic [3:0] ram_drive;

    logic       sync_bus;
    logic       cm_bus;
    logic [3:0] dbus_bus;

    always #5 clk = ~clk;

    mcs4_ram_host_bridge #(.SKIP_SRC(1'b1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(ready_a),
        .req_opa(req_opa), .req_chip(req_chip), .req_reg(req_reg),
        .req_char(req_char), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a),
        .sync(sync_a), .cm_ram(cm_a), .dbus_out(dbus_a), .dbus_in(ram_drive)
    );

    mcs4_ram_host_bridge #(.SKIP_SRC(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(ready_b),
        .req_opa(req_opa), .req_chip(req_chip), .req_reg(req_reg),
        .req_char(req_char), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b),
        .sync(sync_b), .cm_ram(cm_b), .dbus_out(dbus_b), .dbus_in(ram_drive)
    );

    // Both bridges share reset so their frames line up; the idle one drives zeros
    assign sync_bus = sync_a | sync_b;
    assign cm_bus   = cm_a | cm_b;
    assign dbus_bus = dbus_a | dbus_b;

    // Two-chip RAM model (RAM_ID 0 and 1), phase counted from sync
    logic [2:0] r_cnt;
    logic       src_pend, io_act;
    logic [1:0] s_chip, s_reg;
    logic [3:0] s_char, io_opa;
    logic [3:0] mem  [2][4][16];
    logic [3:0] stat [2][4][4];
    logic [3:0] ram_io [2];

    always_comb begin
        ram_drive = 4'h0;
        if (r_cnt == 3'd6 && io_act && io_opa[3] && s_chip < 2'd2) begin
            case (io_opa)
                4'h8, 4'h9, 4'hB:        ram_drive = mem[s_chip[0]][s_reg][s_char];
                4'hC, 4'hD, 4'hE, 4'hF:  ram_drive = stat[s_chip[0]][s_reg][io_opa[1:0]];
                default:                 ram_drive = 4'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int c = 0; c < 2; c++) begin
                ram_io[c] <= 4'h0;
                for (int r = 0; r < 4; r++) begin
                    for (int k = 0; k < 16; k++) mem[c][r][k] <= 4'h0;
                    for (int k = 0; k < 4; k++)  stat[c][r][k] <= 4'h0;
                end
            end
        end
        if (r_cnt == 3'd6 && cm_bus) begin
            s_chip   <= dbus_bus[3:2];
            s_reg    <= dbus_bus[1:0];
            src_pend <= 1'b1;
        end else if (r_cnt == 3'd6 && io_act && !io_opa[3] && s_chip < 2'd2) begin
            case (io_opa)
                4'h0:                    mem[s_chip[0]][s_reg][s_char] <= dbus_bus;
                4'h1:                    ram_io[s_chip[0]] <= dbus_bus;
                4'h4, 4'h5, 4'h6, 4'h7:  stat[s_chip[0]][s_reg][io_opa[1:0]] <= dbus_bus;
                default: ;
            endcase
        end
        if (r_cnt == 3'd7 && src_pend) s_char <= dbus_bus;
        if (r_cnt == 3'd4 && cm_bus) begin
            io_opa <= dbus_bus;
            io_act <= 1'b1;
        end
        r_cnt <= r_cnt + 3'd1;
        if (sync_bus) begin
            r_cnt    <= 3'd0;
            io_act   <= 1'b0;
            src_pend <= 1'b0;
        end
    end

    // Scoreboard
    typedef struct {
        int         dut;
        logic [3:0] rdata;
        longint     lat;
        longint     acc;
    } exp_t;
    exp_t   sb[$];

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    longint last_acc = 0;
    bit     c_valid = 1'b0;
    logic [7:0] c_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, act, act, exp, exp, cyc);
        end
    endtask

    // Response and sync-period monitor
    int  since = 0;
    bit  armed = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            since = 0;
            armed = 1'b0;
        end else begin
            if (rsp_valid_a || rsp_valid_b) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_dut", rsp_valid_b ? 1 : 0, e.dut);
                    check("rsp_rdata", rsp_valid_b ? rdata_b : rdata_a, e.rdata);
                    check("rsp_latency", cyc - e.acc, e.lat);
                end
            end
            since++;
            if (sync_a || sync_b) begin
                if (armed) check("sync_period", since, 8);
                check("sync_match", sync_a, sync_b);
                since = 0;
                armed = 1'b1;
            end
        end
    end

    task automatic do_req(input int dut, input logic [3:0] opa, input logic [1:0] chip,
                          input logic [1:0] rg, input logic [3:0] ch, input logic [3:0] wd,
                          input logic [3:0] exp_rd, input bit chk_gap);
        bit ok = 1'b0;
        exp_t e;
        req_opa = opa; req_chip = chip; req_reg = rg; req_char = ch; req_wdata = wd;
        if (dut == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((dut == 0) ? ready_a : ready_b) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", ok, 1);
        if (ok) begin
            check("accept_at_x3", (dut == 0) ? sync_a : sync_b, 1);
            e.dut = dut;
            e.rdata = exp_rd;
            e.acc = cyc;
            if (dut == 0) begin
                e.lat = (c_valid && c_addr == {chip, rg, ch}) ? 16'd8 : 16'd16;
                c_valid = 1'b1;
                c_addr = {chip, rg, ch};
            end else begin
                e.lat = 16;
            end
            sb.push_back(e);
            if (chk_gap) check("accept_gap", cyc - last_acc, 8);
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) break;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        logic [3:0] io1_before;
        bit found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sync", sync_a, 1);
        check("rst_cm", cm_a, 0);
        check("rst_dbus", dbus_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_rsp_rdata", rdata_a, 0);
        check("rst_b_ready", ready_b, 0);
        check("rst_b_cm", cm_b, 0);
        @(posedge clk);
        #1;
        ram_clr = 1'b0;
        rst = 1'b0;

        // Write then read back; second op hits the SRC cache
        do_req(0, 4'h0, 2'd0, 2'd2, 4'd5, 4'hA, 4'h0, 1'b0);
        do_req(0, 4'h9, 2'd0, 2'd2, 4'd5, 4'h0, 4'hA, 1'b0);
        wait_drain();

        // Status write/read on chip 1, then the same register on chip 0 stays clear
        do_req(0, 4'h5, 2'd1, 2'd3, 4'd0, 4'h6, 4'h0, 1'b0);
        do_req(0, 4'hD, 2'd1, 2'd3, 4'd0, 4'h0, 4'h6, 1'b0);
        do_req(0, 4'hD, 2'd0, 2'd3, 4'd0, 4'h0, 4'h0, 1'b0);
        wait_drain();

        // No SRC skipping: every op sends SRC, cm_ram high in its X2
        do_req(1, 4'h9, 2'd0, 2'd2, 4'd5, 4'h0, 4'hA, 1'b0);
        repeat (7) @(negedge clk);
        check("src_cm_x2_1", cm_b, 1);
        check("src_dbus_x2_1", dbus_b, 4'b0010);
        do_req(1, 4'h9, 2'd0, 2'd2, 4'd5, 4'h0, 4'hA, 1'b0);
        repeat (7) @(negedge clk);
        check("src_cm_x2_2", cm_b, 1);
        check("src_dbus_x2_2", dbus_b, 4'b0010);
        wait_drain();

        // Reset during M2 of the CMD frame drops the write
        req_opa = 4'h0; req_chip = 2'd0; req_reg = 2'd2; req_char = 4'd5; req_wdata = 4'hF;
        do_req(0, 4'h0, 2'd0, 2'd2, 4'd5, 4'hF, 4'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cm_a && dbus_a == 4'h0) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_point_found", found, 1);
        rst = 1'b1;
        sb.delete();
        c_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (24) @(posedge clk);
        do_req(0, 4'h9, 2'd0, 2'd2, 4'd5, 4'h0, 4'hA, 1'b0);
        wait_drain();

        // Back-to-back requests with req_valid held high
        do_req(0, 4'h0, 2'd0, 2'd2, 4'd6, 4'h3, 4'h0, 1'b0);
        do_req(0, 4'h9, 2'd0, 2'd2, 4'd6, 4'h0, 4'h3, 1'b0);
        do_req(0, 4'h0, 2'd0, 2'd2, 4'd6, 4'h7, 4'h0, 1'b1);
        do_req(0, 4'h9, 2'd0, 2'd2, 4'd6, 4'h0, 4'h7, 1'b1);
        wait_drain();

        // Output port write lands only on chip 0
        io1_before = ram_io[1];
        do_req(0, 4'h1, 2'd0, 2'd2, 4'd6, 4'h9, 4'h0, 1'b0);
        wait_drain();
        check("wmp_ram0_io", ram_io[0], 4'h9);
        check("wmp_ram1_io", ram_io[1], io1_before);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
